mem_access_stage: RTL and testbench

Pipeline MEM stage of the RV32I core, directly downstream of the execute stage. Takes registered EX-stage load/store controls, address (ALU result) and store data, and drives a req/ack data-memory port with byte enables. Extends load data, raises misalignment/bus-timeout exceptions, stalls the pipeline while memory is busy, and registers results into the MEM/WB pipeline register.

---
 rtl/mem_access_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data-memory req/ack port, extends load data,
// raises misaligned/bus-timeout exceptions, and loads the MEM/WB register.
//
// Ports
//   Clk, Reset_n (async, active-low), MEM_Flush
//   EX_*   : load/store controls, address, store data, WB controls
//   DMEM_* : req/we/addr/be/wdata out; rdata/ack in
//   MEM_Stall : holds IF/ID/EX while an access waits
//   MEM_*  : registered MEM/WB outputs
// Parameter TIMEOUT (2..255): wait cycles before a bus-timeout exception.
// Option MEM_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of
// aligning them down.
`timescale 1ns/1ps
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MEM_Flush,
  input  logic        EX_Mem_wr_en,
  input  logic        EX_Mem_rd_en,
  input  logic [2:0]  EX_Mem_op,
  input  logic [31:0] EX_ALU_result,
  input  logic [31:0] EX_Rs2_data,
  input  logic        EX_MemToReg,
  input  logic        EX_RegFile_wr_en,
  input  logic [4:0]  EX_Rd_addr,
  input  logic        EX_Exception,
  output logic        DMEM_req,
  output logic        DMEM_we,
  output logic [31:0] DMEM_addr,
  output logic [3:0]  DMEM_be,
  output logic [31:0] DMEM_wdata,
  input  logic [31:0] DMEM_rdata,
  input  logic        DMEM_ack,
  output logic        MEM_Stall,
  output logic        MEM_RegFile_wr_en,
  output logic        MEM_MemToReg,
  output logic [4:0]  MEM_Rd_addr,
  output logic [31:0] MEM_ALU_result,
  output logic [31:0] MEM_Rd_data,
  output logic        MEM_Exception,
  output logic [1:0]  MEM_Exc_cause
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;

  logic        is_b, is_h, is_w;
  logic        uns;
  logic [1:0]  off;
  logic        misal;
  logic        mem_op;
  logic        trap;
  logic        tmo_now;
  logic [31:0] sh;
  logic [31:0] ext;
  logic [1:0]  cause_n;

  assign is_b = (EX_Mem_op[1:0] == 2'b00);
  assign is_h = (EX_Mem_op[1:0] == 2'b01);
  // 010, 011, 110, 111 all behave as word
  assign is_w = ~is_b & ~is_h;
  assign uns  = EX_Mem_op[2];

  // Lane offset, aligned down to the access size
  always_comb begin
    off        = 2'b00;
    DMEM_be    = 4'hF;
    DMEM_wdata = EX_Rs2_data;
    unique case (1'b1)
      is_b: begin
        off        = EX_ALU_result[1:0];
        DMEM_be    = 4'b0001 << off;
        DMEM_wdata = {4{EX_Rs2_data[7:0]}};
      end
      is_h: begin
        off        = {EX_ALU_result[1], 1'b0};
        DMEM_be    = 4'b0011 << off;
        DMEM_wdata = {2{EX_Rs2_data[15:0]}};
      end
      default: begin
        off        = 2'b00;
        DMEM_be    = 4'hF;
        DMEM_wdata = EX_Rs2_data;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = (is_h & EX_ALU_result[0])
               | (is_w & (|EX_ALU_result[1:0]));
`else
  assign misal = 1'b0;
`endif

  assign mem_op = EX_Mem_rd_en | EX_Mem_wr_en;
  assign trap   = mem_op & ~EX_Exception & misal;

  // Gated by Reset_n so req drops asynchronously on reset
  assign DMEM_req = Reset_n & mem_op & ~EX_Exception
                  & ~misal & ~MEM_Flush;
  assign DMEM_we   = DMEM_req & EX_Mem_wr_en;
  assign DMEM_addr = {EX_ALU_result[31:2], 2'b00};

  // Ack in the last allowed cycle still wins over timeout
  assign tmo_now = DMEM_req & (state == WAIT)
                 & (cnt == TMO) & ~DMEM_ack;

  assign MEM_Stall = DMEM_req & ~DMEM_ack & ~tmo_now;

  assign sh = DMEM_rdata >> {off, 3'b000};

  always_comb begin
    ext = DMEM_rdata;
    unique case (1'b1)
      is_b:    ext = {{24{~uns & sh[7]}}, sh[7:0]};
      is_h:    ext = {{16{~uns & sh[15]}}, sh[15:0]};
      default: ext = DMEM_rdata;
    endcase
  end

  assign cause_n = tmo_now ? 2'b11 :
                   trap    ? (EX_Mem_rd_en ? 2'b01 : 2'b10) :
                             2'b00;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (DMEM_req & ~DMEM_ack) begin
          state_n = WAIT;
          cnt_n   = 8'd1;
        end
      end
      WAIT: begin
        if (~DMEM_req | DMEM_ack | tmo_now) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      MEM_RegFile_wr_en <= 1'b0;
      MEM_MemToReg      <= 1'b0;
      MEM_Rd_addr       <= 5'd0;
      MEM_ALU_result    <= 32'd0;
      MEM_Rd_data       <= 32'd0;
      MEM_Exception     <= 1'b0;
      MEM_Exc_cause     <= 2'b00;
    end else if (MEM_Stall | MEM_Flush) begin
      MEM_RegFile_wr_en <= 1'b0;
      MEM_MemToReg      <= 1'b0;
      MEM_Exception     <= 1'b0;
      MEM_Exc_cause     <= 2'b00;
    end else begin
      MEM_RegFile_wr_en <= EX_RegFile_wr_en & ~trap & ~tmo_now;
      MEM_MemToReg      <= EX_MemToReg;
      MEM_Rd_addr       <= EX_Rd_addr;
      MEM_ALU_result    <= EX_ALU_result;
      MEM_Rd_data       <= (DMEM_req & EX_Mem_rd_en & DMEM_ack)
                         ? ext : 32'd0;
      MEM_Exception     <= EX_Exception | trap | tmo_now;
      MEM_Exc_cause     <= cause_n;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level model
// plus directed flush / reset-in-wait scenarios.
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int T = 16;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        MEM_Flush = 1'b0;
  logic        EX_Mem_wr_en = 1'b0;
  logic        EX_Mem_rd_en = 1'b0;
  logic [2:0]  EX_Mem_op = 3'd0;
  logic [31:0] EX_ALU_result = 32'd0;
  logic [31:0] EX_Rs2_data = 32'd0;
  logic        EX_MemToReg = 1'b0;
  logic        EX_RegFile_wr_en = 1'b0;
  logic [4:0]  EX_Rd_addr = 5'd0;
  logic        EX_Exception = 1'b0;
  logic        DMEM_req, DMEM_we;
  logic [31:0] DMEM_addr, DMEM_wdata;
  logic [3:0]  DMEM_be;
  logic [31:0] DMEM_rdata = 32'd0;
  logic        DMEM_ack = 1'b0;
  logic        MEM_Stall;
  logic        MEM_RegFile_wr_en, MEM_MemToReg;
  logic [4:0]  MEM_Rd_addr;
  logic [31:0] MEM_ALU_result, MEM_Rd_data;
  logic        MEM_Exception;
  logic [1:0]  MEM_Exc_cause;

  int nvec = 0;
  int nerr = 0;

  mem_access_stage #(.TIMEOUT(T)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .MEM_Flush(MEM_Flush),
    .EX_Mem_wr_en(EX_Mem_wr_en), .EX_Mem_rd_en(EX_Mem_rd_en),
    .EX_Mem_op(EX_Mem_op), .EX_ALU_result(EX_ALU_result),
    .EX_Rs2_data(EX_Rs2_data), .EX_MemToReg(EX_MemToReg),
    .EX_RegFile_wr_en(EX_RegFile_wr_en), .EX_Rd_addr(EX_Rd_addr),
    .EX_Exception(EX_Exception),
    .DMEM_req(DMEM_req), .DMEM_we(DMEM_we), .DMEM_addr(DMEM_addr),
    .DMEM_be(DMEM_be), .DMEM_wdata(DMEM_wdata),
    .DMEM_rdata(DMEM_rdata), .DMEM_ack(DMEM_ack),
    .MEM_Stall(MEM_Stall),
    .MEM_RegFile_wr_en(MEM_RegFile_wr_en), .MEM_MemToReg(MEM_MemToReg),
    .MEM_Rd_addr(MEM_Rd_addr), .MEM_ALU_result(MEM_ALU_result),
    .MEM_Rd_data(MEM_Rd_data), .MEM_Exception(MEM_Exception),
    .MEM_Exc_cause(MEM_Exc_cause)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] rdat);
    int sz, off;
    logic [31:0] v, mask;
    sz = size_of(op);
    off = int'(a[1:0]) & ~(sz - 1);
    v = rdat >> (8 * off);
    if (sz < 4) begin
      mask = (32'h1 << (8 * sz)) - 32'h1;
      v = v & mask;
      if (!op[2] && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic set_ex(input logic rd, input logic wr,
                        input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic rf,
                        input logic m2r, input logic [4:0] rda,
                        input logic up);
    EX_Mem_rd_en = rd;
    EX_Mem_wr_en = wr;
    EX_Mem_op = op;
    EX_ALU_result = a;
    EX_Rs2_data = d;
    EX_RegFile_wr_en = rf;
    EX_MemToReg = m2r;
    EX_Rd_addr = rda;
    EX_Exception = up;
  endtask

  // One instruction; lat = cycles until the memory acks (0 = same cycle)
  task automatic run_op(input logic rd, input logic wr,
                        input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rdat,
                        input logic rf, input logic m2r,
                        input logic [4:0] rda, input logic up,
                        input int lat);
    int sz, off, last;
    logic mis, trap, acc, tmo;
    logic [3:0] ebe;
    logic [31:0] ewd;
    logic [1:0] ecause;
    sz = size_of(op);
    off = int'(a[1:0]) & ~(sz - 1);
    mis = (sz == 2) ? a[0] : (sz == 4) ? (a[1:0] != 2'b00) : 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = (rd | wr) & ~up & mis;
`else
    trap = 1'b0;
`endif
    acc = (rd | wr) & ~up & ~trap;
    tmo = acc && (lat > T);
    last = acc ? ((lat < T) ? lat : T) : 0;
    ebe = 4'((1 << sz) - 1) << off;
    for (int i = 0; i < 4; i++) ewd[8*i+:8] = d[8*(i%sz)+:8];
    for (int k = 0; k <= last; k++) begin
      @(negedge Clk);
      set_ex(rd, wr, op, a, d, rf, m2r, rda, up);
      DMEM_rdata = rdat;
      DMEM_ack = acc ? (k == lat) : 1'($urandom);
      #1;
      chk("req", DMEM_req, acc);
      chk("stall", MEM_Stall, acc && (k < lat) && (k < T));
      if (acc && k == 0) begin
        chk("addr", DMEM_addr, {a[31:2], 2'b00});
        chk("be", DMEM_be, ebe);
        chk("we", DMEM_we, wr);
        if (wr) chk("wdata", DMEM_wdata, ewd);
      end
      @(posedge Clk);
      #1;
      if (k < last) begin
        chk("bub_wr", MEM_RegFile_wr_en, 1'b0);
        chk("bub_exc", MEM_Exception, 1'b0);
        chk("bub_m2r", MEM_MemToReg, 1'b0);
      end
    end
    ecause = tmo ? 2'b11 : trap ? (rd ? 2'b01 : 2'b10) : 2'b00;
    chk("wr_en", MEM_RegFile_wr_en, rf & ~trap & ~tmo);
    chk("m2r", MEM_MemToReg, m2r);
    chk("rd_addr", MEM_Rd_addr, rda);
    chk("alu", MEM_ALU_result, a);
    chk("rd_data", MEM_Rd_data,
        (acc && rd && !tmo) ? load_val(op, a, rdat) : 32'd0);
    chk("exc", MEM_Exception, up | trap | tmo);
    chk("cause", MEM_Exc_cause, ecause);
    DMEM_ack = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, DMEM_req, 1'b0);
    chk({tag, "_wr"}, MEM_RegFile_wr_en, 1'b0);
    chk({tag, "_m2r"}, MEM_MemToReg, 1'b0);
    chk({tag, "_rda"}, MEM_Rd_addr, 5'd0);
    chk({tag, "_alu"}, MEM_ALU_result, 32'd0);
    chk({tag, "_rdd"}, MEM_Rd_data, 32'd0);
    chk({tag, "_exc"}, MEM_Exception, 1'b0);
    chk({tag, "_cause"}, MEM_Exc_cause, 2'b00);
  endtask

  logic [2:0] ops [8] = '{3'd0, 3'd1, 3'd2, 3'd4,
                          3'd5, 3'd3, 3'd6, 3'd7};

  initial begin
    // Reset with a load pending: req must stay low
    set_ex(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 1'b1, 1'b1, 5'd3, 1'b0);
    repeat (2) @(negedge Clk);
    #1;
    chk_zero("rst");
    @(negedge Clk);
    set_ex(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    Reset_n = 1'b1;

    // Directed cases
    run_op(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,
           1'b0, 1'b0, 5'd0, 1'b0, 0);
    run_op(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FFFF01,
           1'b1, 1'b1, 5'd5, 1'b0, 0);
    chk("lb", MEM_Rd_data, 32'hFFFFFF80);
    run_op(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FFFF01,
           1'b1, 1'b1, 5'd5, 1'b0, 0);
    chk("lbu", MEM_Rd_data, 32'h00000080);
    run_op(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'h80FFFF01,
           1'b1, 1'b1, 5'd6, 1'b0, 1);
    chk("lhu", MEM_Rd_data, 32'h000080FF);
    run_op(1'b0, 1'b1, 3'd0, 32'h101, 32'h12345678, 32'h0,
           1'b0, 1'b0, 5'd0, 1'b0, 3);
    run_op(1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 32'hCAFEF00D,
           1'b1, 1'b1, 5'd7, 1'b0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("lw_mis", MEM_Exc_cause, 2'b01);
`else
    chk("lw_mis", MEM_Rd_data, 32'hCAFEF00D);
`endif
    run_op(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 32'h0,
           1'b1, 1'b1, 5'd8, 1'b0, T + 4);
    chk("tmo", MEM_Exc_cause, 2'b11);
    run_op(1'b1, 1'b0, 3'd2, 32'h204, 32'h0, 32'h55AA55AA,
           1'b1, 1'b1, 5'd9, 1'b0, T);
    run_op(1'b0, 1'b0, 3'd0, 32'h7777, 32'h0, 32'h0,
           1'b1, 1'b0, 5'd10, 1'b1, 0);

    // Flush while waiting
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      set_ex(1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 1'b1, 1'b1, 5'd11, 1'b0);
      DMEM_ack = 1'b0;
      #1;
      chk("fl_stall", MEM_Stall, 1'b1);
    end
    @(negedge Clk);
    MEM_Flush = 1'b1;
    #1;
    chk("fl_req", DMEM_req, 1'b0);
    chk("fl_stall0", MEM_Stall, 1'b0);
    @(posedge Clk);
    #1;
    chk("fl_wr", MEM_RegFile_wr_en, 1'b0);
    chk("fl_exc", MEM_Exception, 1'b0);
    @(negedge Clk);
    MEM_Flush = 1'b0;
    run_op(1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 32'h01020304,
           1'b1, 1'b1, 5'd11, 1'b0, T - 1);

    // Reset while waiting
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      set_ex(1'b0, 1'b1, 3'd2, 32'h400, 32'h1, 1'b0, 1'b0, 5'd0, 1'b0);
      DMEM_ack = 1'b0;
    end
    #2;
    Reset_n = 1'b0;
    #1;
    chk_zero("rstw");
    @(negedge Clk);
    Reset_n = 1'b1;
    run_op(1'b1, 1'b0, 3'd1, 32'h402, 32'h0, 32'h8001FFFF,
           1'b1, 1'b1, 5'd12, 1'b0, 2);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int kind, lat, p;
      logic rd, wr;
      kind = int'($urandom_range(0, 3));
      rd = (kind == 0) || (kind == 3);
      wr = (kind == 1);
      p = int'($urandom_range(0, 19));
      if (p < 14) lat = int'($urandom_range(0, 3));
      else if (p < 17) lat = int'($urandom_range(4, T));
      else lat = T + 1 + int'($urandom_range(0, 3));
      run_op(rd, wr, ops[$urandom_range(0, 7)], $urandom, $urandom,
             $urandom, 1'($urandom), 1'($urandom), 5'($urandom),
             ($urandom_range(0, 15) == 0), lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
